// File: rtl/tpg_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : tpg_pattern_sched
// Brief    : Frame-synchronous playlist scheduler driving the TPG pattern
//            select. Steps through (mode, dwell) entries on VS rising edges
//            and executes host RUN/PAUSE/STEP/JUMP commands on frame
//            boundaries only.
// Revision : 1.0 - initial release
// ============================================================================
module tpg_pattern_sched #(
    parameter int NUM_ENTRIES = 8,
    parameter int MODE_W      = 4,
    parameter int DWELL_W     = 8,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic               I_tpg_clk,
    input  logic               I_tpg_rst,
    input  logic               I_tpg_vs,
    input  logic               I_wr_en,
    input  logic [IDX_W-1:0]   I_wr_addr,
    input  logic [MODE_W-1:0]  I_wr_mode,
    input  logic [DWELL_W-1:0] I_wr_dwell,
    input  logic [IDX_W:0]     I_cfg_len,
    input  logic               I_cmd_valid,
    output logic               O_cmd_ready,
    input  logic [1:0]         I_cmd_op,
    input  logic [IDX_W-1:0]   I_cmd_arg,
    output logic [MODE_W-1:0]  O_tpg_mode,
    output logic               O_mode_upd,
    output logic [IDX_W-1:0]   O_cur_idx,
    output logic               O_running,
    output logic [15:0]        O_frame_cnt
);

    localparam logic [1:0]         c_OP_RUN    = 2'd0;
    localparam logic [1:0]         c_OP_PAUSE  = 2'd1;
    localparam logic [1:0]         c_OP_STEP   = 2'd2;
    localparam logic [1:0]         c_OP_JUMP   = 2'd3;
    localparam logic [DWELL_W-1:0] c_DWELL_RST = DWELL_W'(60);
    localparam logic [IDX_W:0]     c_LEN_MAX   = (IDX_W+1)'(NUM_ENTRIES);

    typedef enum logic [0:0] {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_vs;
    logic                 w_bnd;
    logic [MODE_W-1:0]    r_mode_mem  [NUM_ENTRIES];
    logic [DWELL_W-1:0]   r_dwell_mem [NUM_ENTRIES];
    logic [IDX_W-1:0]     r_idx;
    logic [MODE_W-1:0]    r_mode;
    logic [DWELL_W-1:0]   r_cur_dwell;
    logic [DWELL_W-1:0]   r_dwell_cnt, w_dwell_cnt_nxt;
    logic                 r_upd;
    logic [15:0]          r_frame_cnt;
    logic                 r_running;
    logic                 r_pend;
    logic [1:0]           r_pend_op;
    logic [IDX_W-1:0]     r_pend_arg;
    logic                 r_ready;
    logic                 r_load_req, w_load;
    logic [IDX_W-1:0]     r_load_idx, w_load_idx;
    logic                 w_exec;
    logic [IDX_W:0]       w_len;
    logic [IDX_W:0]       w_idx_inc;
    logic [IDX_W-1:0]     w_idx_next;
    logic [IDX_W-1:0]     w_jump_tgt;
    logic [DWELL_W:0]     w_dwell_inc;
    logic [DWELL_W-1:0]   w_mem_dwell;

    assign w_bnd = I_tpg_vs & ~r_vs;

    // Effective playlist length and derived successor / jump target.
    always_comb begin
        w_len = I_cfg_len;
        if (I_cfg_len == '0) begin
            w_len = (IDX_W+1)'(1);
        end else if (I_cfg_len > c_LEN_MAX) begin
            w_len = c_LEN_MAX;
        end
        w_idx_inc   = {1'b0, r_idx} + (IDX_W+1)'(1);
        w_idx_next  = (w_idx_inc >= w_len) ? '0 : w_idx_inc[IDX_W-1:0];
        w_jump_tgt  = ({1'b0, r_pend_arg} < w_len) ? r_pend_arg : '0;
        w_dwell_inc = {1'b0, r_dwell_cnt} + (DWELL_W+1)'(1);
    end

    // Boundary decision: pending command first, then RUN dwell advance.
    always_comb begin
        w_state_nxt     = r_state;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_load          = 1'b0;
        w_load_idx      = r_idx;
        w_exec          = 1'b0;
        if (w_bnd) begin
            if (r_pend) begin
                w_exec = 1'b1;
                case (r_pend_op)
                    c_OP_RUN:   w_state_nxt = ST_RUN;
                    c_OP_PAUSE: w_state_nxt = ST_PAUSE;
                    c_OP_STEP: begin
                        w_load          = 1'b1;
                        w_load_idx      = w_idx_next;
                        w_dwell_cnt_nxt = '0;
                        w_state_nxt     = ST_PAUSE;
                    end
                    default: begin
                        w_load          = 1'b1;
                        w_load_idx      = w_jump_tgt;
                        w_dwell_cnt_nxt = '0;
                    end
                endcase
            end else if (r_state == ST_RUN) begin
                if (w_dwell_inc >= {1'b0, r_cur_dwell}) begin
                    w_load          = 1'b1;
                    w_load_idx      = w_idx_next;
                    w_dwell_cnt_nxt = '0;
                end else begin
                    w_dwell_cnt_nxt = w_dwell_inc[DWELL_W-1:0];
                end
            end
        end
    end

    // State register, dwell counter, frame counter and load request.
    always_ff @(posedge I_tpg_clk) begin
        if (I_tpg_rst) begin
            r_state     <= ST_PAUSE;
            r_dwell_cnt <= '0;
            r_vs        <= 1'b1;
            r_frame_cnt <= '0;
            r_running   <= 1'b0;
            r_load_req  <= 1'b0;
            r_load_idx  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_vs        <= I_tpg_vs;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_bnd};
            r_running   <= (w_state_nxt == ST_RUN);
            r_load_req  <= w_load;
            r_load_idx  <= w_load_idx;
        end
    end

    // Command handshake: one pending command, ready returns after it executes.
    always_ff @(posedge I_tpg_clk) begin
        if (I_tpg_rst) begin
            r_pend     <= 1'b0;
            r_pend_op  <= '0;
            r_pend_arg <= '0;
            r_ready    <= 1'b0;
        end else if (I_cmd_valid && r_ready) begin
            r_pend     <= 1'b1;
            r_pend_op  <= I_cmd_op;
            r_pend_arg <= I_cmd_arg;
            r_ready    <= 1'b0;
        end else if (w_exec) begin
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_ready <= ~r_pend;
        end
    end

    // Playlist storage; reads in the load cycle see pre-write contents.
    always_ff @(posedge I_tpg_clk) begin
        if (I_tpg_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mode_mem[i]  <= MODE_W'(i);
                r_dwell_mem[i] <= c_DWELL_RST;
            end
        end else if (I_wr_en) begin
            r_mode_mem[I_wr_addr]  <= I_wr_mode;
            r_dwell_mem[I_wr_addr] <= I_wr_dwell;
        end
    end

    assign w_mem_dwell = r_dwell_mem[r_load_idx];

    // Load stage: latch the selected entry the cycle after the boundary.
    always_ff @(posedge I_tpg_clk) begin
        if (I_tpg_rst) begin
            r_idx       <= '0;
            r_mode      <= '0;
            r_cur_dwell <= c_DWELL_RST;
            r_upd       <= 1'b0;
        end else begin
            r_upd <= r_load_req;
            if (r_load_req) begin
                r_idx       <= r_load_idx;
                r_mode      <= r_mode_mem[r_load_idx];
                r_cur_dwell <= (w_mem_dwell == '0) ? DWELL_W'(1) : w_mem_dwell;
            end
        end
    end

    assign O_cmd_ready = r_ready;
    assign O_tpg_mode  = r_mode;
    assign O_mode_upd  = r_upd;
    assign O_cur_idx   = r_idx;
    assign O_running   = r_running;
    assign O_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tpg_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpg_pattern_sched
// Brief    : Directed table-driven bench for tpg_pattern_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpg_pattern_sched;

    localparam int c_OP_RUN = 0, c_OP_PAUSE = 1, c_OP_STEP = 2, c_OP_JUMP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_mode = '0;
    logic [7:0] wr_dwell = '0;
    logic [3:0] cfg_len = 4'd8;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_arg = '0;
    logic [3:0] tpg_mode;
    logic       mode_upd;
    logic [2:0] cur_idx;
    logic       running;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit c; int op; int arg;      // command sent before this frame
        bit w; int wa; int wm;       // playlist write in the load cycle
        int mode; bit upd; int idx; bit run;
    } vec_t;

    vec_t tbl[23];

    tpg_pattern_sched dut (
        .I_tpg_clk   (clk),
        .I_tpg_rst   (rst),
        .I_tpg_vs    (vs),
        .I_wr_en     (wr_en),
        .I_wr_addr   (wr_addr),
        .I_wr_mode   (wr_mode),
        .I_wr_dwell  (wr_dwell),
        .I_cfg_len   (cfg_len),
        .I_cmd_valid (cmd_valid),
        .O_cmd_ready (cmd_ready),
        .I_cmd_op    (cmd_op),
        .I_cmd_arg   (cmd_arg),
        .O_tpg_mode  (tpg_mode),
        .O_mode_upd  (mode_upd),
        .O_cur_idx   (cur_idx),
        .O_running   (running),
        .O_frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int a, input int m, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_mode = 4'(m); wr_dwell = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input int op, input int arg);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_arg = 3'(arg);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ready_after_accept", int'(cmd_ready), 0);
    endtask

    // One frame: VS high for two cycles; records mode_upd position (1-based
    // negedge count after the VS rise) and ready around the boundary.
    task automatic run_frame(input bit do_wr, input int wa, input int wm,
                             output int upd_pos, output int upd_cnt,
                             output logic rdy_before, output logic rdy_after);
        upd_pos = -1;
        upd_cnt = 0;
        rdy_after = 1'bx;
        @(negedge clk);
        rdy_before = cmd_ready;
        vs = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (mode_upd) begin
                upd_cnt++;
                upd_pos = j;
            end
            if (j == 1) begin
                rdy_after = cmd_ready;
                if (do_wr) begin
                    wr_en = 1'b1; wr_addr = 3'(wa); wr_mode = 4'(wm); wr_dwell = 8'd1;
                end
            end
            if (j == 2) begin
                wr_en = 1'b0;
                vs = 1'b0;
            end
        end
    endtask

    initial begin
        int   up, uc;
        logic rb, ra;

        tbl[0]  = '{1, c_OP_RUN,   0, 0, 0, 0,  0, 0, 0, 1};
        tbl[1]  = '{1, c_OP_JUMP,  0, 0, 0, 0,  9, 1, 0, 1};
        tbl[2]  = '{0, 0,          0, 0, 0, 0,  9, 0, 0, 1};
        tbl[3]  = '{0, 0,          0, 0, 0, 0,  3, 1, 1, 1};
        tbl[4]  = '{0, 0,          0, 0, 0, 0, 10, 1, 2, 1};
        tbl[5]  = '{0, 0,          0, 0, 0, 0,  9, 1, 0, 1};
        tbl[6]  = '{0, 0,          0, 0, 0, 0,  9, 0, 0, 1};
        tbl[7]  = '{0, 0,          0, 0, 0, 0,  3, 1, 1, 1};
        tbl[8]  = '{1, c_OP_PAUSE, 0, 0, 0, 0,  3, 0, 1, 0};
        tbl[9]  = '{1, c_OP_STEP,  0, 0, 0, 0, 10, 1, 2, 0};
        tbl[10] = '{1, c_OP_STEP,  0, 0, 0, 0,  9, 1, 0, 0};
        tbl[11] = '{1, c_OP_JUMP,  5, 0, 0, 0,  9, 1, 0, 0};
        tbl[12] = '{1, c_OP_RUN,   0, 0, 0, 0,  9, 0, 0, 1};
        tbl[13] = '{0, 0,          0, 0, 0, 0,  9, 0, 0, 1};
        tbl[14] = '{1, c_OP_JUMP,  2, 0, 0, 0, 10, 1, 2, 1};
        tbl[15] = '{0, 0,          0, 0, 0, 0,  9, 1, 0, 1};
        tbl[16] = '{0, 0,          0, 0, 0, 0,  9, 0, 0, 1};
        tbl[17] = '{0, 0,          0, 1, 1, 12, 3, 1, 1, 1};
        tbl[18] = '{0, 0,          0, 0, 0, 0, 10, 1, 2, 1};
        tbl[19] = '{0, 0,          0, 0, 0, 0,  9, 1, 0, 1};
        tbl[20] = '{0, 0,          0, 0, 0, 0,  9, 0, 0, 1};
        tbl[21] = '{0, 0,          0, 0, 0, 0, 12, 1, 1, 1};
        tbl[22] = '{0, 0,          0, 0, 0, 0, 10, 1, 2, 1};

        // Reset and idle frames
        repeat (3) @(negedge clk);
        check("ready_in_reset", int'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(cmd_ready), 1);
        check("rst_mode", int'(tpg_mode), 0);
        check("rst_idx", int'(cur_idx), 0);
        check("rst_running", int'(running), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, up, uc, rb, ra);
            check("idle_upd_cnt", uc, 0);
            check("idle_mode", int'(tpg_mode), 0);
        end
        check("idle_frame_cnt", int'(frame_cnt), 3);
        check("idle_ready", int'(cmd_ready), 1);

        // Program playlist
        write_entry(0, 9, 2);
        write_entry(1, 3, 1);
        write_entry(2, 10, 0);
        cfg_len = 4'd3;

        // Table-driven frames
        for (int i = 0; i < 23; i++) begin
            if (tbl[i].c) send_cmd(tbl[i].op, tbl[i].arg);
            run_frame(tbl[i].w, tbl[i].wa, tbl[i].wm, up, uc, rb, ra);
            check($sformatf("v%0d_mode", i), int'(tpg_mode), tbl[i].mode);
            check($sformatf("v%0d_idx", i), int'(cur_idx), tbl[i].idx);
            check($sformatf("v%0d_running", i), int'(running), int'(tbl[i].run));
            check($sformatf("v%0d_upd_cnt", i), uc, tbl[i].upd ? 1 : 0);
            check($sformatf("v%0d_upd_pos", i), up, tbl[i].upd ? 2 : -1);
            if (tbl[i].c) begin
                check($sformatf("v%0d_ready_pre_bnd", i), int'(rb), 0);
                check($sformatf("v%0d_ready_post_bnd", i), int'(ra), 1);
            end
        end
        check("frame_cnt_26", int'(frame_cnt), 26);

        // Reset with a STEP pending at idx 2
        send_cmd(c_OP_STEP, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idx", int'(cur_idx), 0);
        check("mid_rst_mode", int'(tpg_mode), 0);
        check("mid_rst_frame_cnt", int'(frame_cnt), 0);
        check("mid_rst_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("mid_rst_ready_rel", int'(cmd_ready), 1);
        run_frame(0, 0, 0, up, uc, rb, ra);
        check("dropped_cmd_upd", uc, 0);
        check("dropped_cmd_idx", int'(cur_idx), 0);
        check("dropped_cmd_mode", int'(tpg_mode), 0);
        check("dropped_cmd_running", int'(running), 0);
        check("post_rst_frame_cnt", int'(frame_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
